// File: rtl/vga_scanout.sv
// 640x480@60 VGA scan-out of the 320x240x3bpp tron frame buffer, pixel-doubled in both axes.
// Counters advance on a divided pixel tick; sync and colour are registered one tick behind them.
module vga_scanout #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clock,
    input  logic        reset,
    output logic [18:0] ram_address,
    input  logic [2:0]  ram_read_data,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [2:0]  div_q, div_d;
    logic [9:0]  hc_q, hc_d;
    logic [9:0]  vc_q, vc_d;
    logic        tick;
    logic        visible;
    logic [8:0]  x, y;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic [3:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic        fs_q, fs_d;

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? 3'd0 : div_q + 3'd1;
        hc_d  = hc_q;
        vc_d  = vc_q;
        if (tick) begin
            if (hc_q == H_LAST) begin
                hc_d = 10'd0;
                vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end

        // Raised the clock before a tick at (0,0), so the pulse coincides with that tick clock.
        fs_d = (div_d == DIV_LAST) && (hc_d == 10'd0) && (vc_d == 10'd0);

        visible = (hc_q < H_VIS) && (vc_q < V_VIS);
        x = hc_q[9:1];
        y = vc_q[9:1];
        ram_address = visible ? ((19'(y) << 8) + (19'(y) << 6) + 19'(x)) : 19'd0;

        hsync_d = ~((hc_q >= HS_BEG) && (hc_q < HS_END));
        vsync_d = ~((vc_q >= VS_BEG) && (vc_q < VS_END));
        r_d = visible ? {4{ram_read_data[2]}} : 4'd0;
        g_d = visible ? {4{ram_read_data[1]}} : 4'd0;
        b_d = visible ? {4{ram_read_data[0]}} : 4'd0;
    end

    // The address has been stable for at least one full clock by the tick, so read data is valid here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q   <= 3'd0;
            hc_q    <= 10'd0;
            vc_q    <= 10'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            r_q     <= 4'd0;
            g_q     <= 4'd0;
            b_q     <= 4'd0;
            fs_q    <= 1'b0;
        end else begin
            div_q <= div_d;
            fs_q  <= fs_d;
            if (tick) begin
                hc_q    <= hc_d;
                vc_q    <= vc_d;
                hsync_q <= hsync_d;
                vsync_q <= vsync_d;
                r_q     <= r_d;
                g_q     <= g_d;
                b_q     <= b_d;
            end
        end
    end

    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout with shortened blanking so whole frames fit in a short run.
// Expected outputs come from the clock count since reset release using plain frame arithmetic.
module tb_vga_scanout;

    localparam int CD = 2;
    localparam int HV = 40, HF = 4, HS = 8, HB = 4;
    localparam int VV = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [18:0] ram_address;
    logic [2:0]  ram_read_data = 3'd0;
    logic        vga_hsync, vga_vsync;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        frame_start;

    logic [2:0] mem [0:76799];

    int compared = 0;
    int mismatched = 0;
    int n = 0;

    vga_scanout #(
        .CLK_DIV(CD),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ram_address(ram_address),
        .ram_read_data(ram_read_data),
        .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    always @(posedge clock) ram_read_data <= mem[ram_address];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h (clock %0d)", tag, obs, exp, n);
        end
    endtask

    function automatic int pix_addr(input int hc, input int vc);
        return (hc < HV && vc < VV) ? 320 * (vc / 2) + hc / 2 : 0;
    endfunction

    task automatic check_all();
        int t, q, hc, vc;
        logic [2:0] d;
        logic [11:0] rgb;
        logic hs, vs;
        t  = n / CD;
        hc = (t % FRAME) % HT;
        vc = (t % FRAME) / HT;
        chk("addr", 32'(ram_address), 32'(pix_addr(hc, vc)));
        chk("frame_start", 32'(frame_start), 32'(((n + 1) % CD == 0) && (t % FRAME == 0)));
        if (t == 0) begin
            hs = 1'b1; vs = 1'b1; rgb = 12'h000;
        end else begin
            q  = (t - 1) % FRAME;
            hc = q % HT;
            vc = q / HT;
            hs = !(hc >= HV + HF && hc < HV + HF + HS);
            vs = !(vc >= VV + VF && vc < VV + VF + VS);
            d  = mem[pix_addr(hc, vc)];
            rgb = (hc < HV && vc < VV) ? {{4{d[2]}}, {4{d[1]}}, {4{d[0]}}} : 12'h000;
        end
        chk("hsync", 32'(vga_hsync), 32'(hs));
        chk("vsync", 32'(vga_vsync), 32'(vs));
        chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(rgb));
    endtask

    task automatic step();
        @(posedge clock);
        n++;
        @(negedge clock);
        check_all();
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b0;
        n = 0;
    endtask

    initial begin
        int fs_cnt, fs_first, fs_second, hlow, vlow, white;

        for (int i = 0; i < 76800; i++) mem[i] = 3'($urandom);
        repeat (3) @(negedge clock);
        check_all();
        release_reset();

        // Random picture over two frames: full model check, frame_start spacing, sync duty.
        fs_cnt = 0; fs_first = -1; fs_second = -1; hlow = 0; vlow = 0;
        for (int i = 0; i < 2 * CD * FRAME + 4; i++) begin
            step();
            if (frame_start === 1'b1) begin
                if (fs_cnt == 0) fs_first = n;
                else if (fs_cnt == 1) fs_second = n;
                fs_cnt++;
            end
            if (n >= CD && n < CD + CD * FRAME) begin
                if (vga_hsync === 1'b0) hlow++;
                if (vga_vsync === 1'b0) vlow++;
            end
        end
        chk("fs_first", 32'(fs_first), 32'd1);
        chk("fs_period", 32'(fs_second - fs_first), 32'(CD * FRAME));
        chk("fs_count", 32'(fs_cnt), 32'd3);
        chk("hsync_low_clocks", 32'(hlow), 32'(HS * VT * CD));
        chk("vsync_low_clocks", 32'(vlow), 32'(VS * HT * CD));

        // Asynchronous reset mid-line at hc=20, vc=6.
        run_to(n + CD * FRAME - ((n / CD) % FRAME) * CD + (6 * HT + 20) * CD);
        #2 reset = 1'b1;
        #1;
        chk("arst_hsync", 32'(vga_hsync), 32'd1);
        chk("arst_vsync", 32'(vga_vsync), 32'd1);
        chk("arst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h000);
        chk("arst_fs", 32'(frame_start), 32'd0);
        chk("arst_addr", 32'(ram_address), 32'd0);
        n = 0;
        mem[641] = 3'b110;
        mem[642] = 3'b011;
        mem[643] = 3'b111;
        mem[644] = 3'b000;
        repeat (2) @(negedge clock);
        check_all();
        release_reset();
        step();
        chk("fs_after_arst", 32'(frame_start), 32'd1);

        // Directed address, colour and sync-edge points.
        run_to((5 * HT + 3) * CD);
        chk("addr_3_5", 32'(ram_address), 32'd641);
        run_to((5 * HT + 4) * CD);
        chk("rgb_110", 32'({vga_r, vga_g, vga_b}), 32'hFF0);
        run_to((5 * HT + 5) * CD);
        chk("rgb_011", 32'({vga_r, vga_g, vga_b}), 32'h0FF);
        run_to((5 * HT + 7) * CD);
        chk("rgb_111", 32'({vga_r, vga_g, vga_b}), 32'hFFF);
        run_to((5 * HT + 9) * CD);
        chk("rgb_000", 32'({vga_r, vga_g, vga_b}), 32'h000);
        run_to((5 * HT + HV - 1) * CD);
        chk("addr_last_x", 32'(ram_address), 32'(320 * 2 + (HV - 1) / 2));
        run_to((5 * HT + HV) * CD);
        chk("addr_hblank", 32'(ram_address), 32'd0);
        run_to((5 * HT + HV + HF) * CD);
        chk("hsync_before_fall", 32'(vga_hsync), 32'd1);
        run_to((5 * HT + HV + HF + 1) * CD);
        chk("hsync_fall", 32'(vga_hsync), 32'd0);
        run_to((5 * HT + HV + HF + HS + 1) * CD);
        chk("hsync_rise", 32'(vga_hsync), 32'd1);
        run_to(((VV - 1) * HT + HV - 1) * CD);
        chk("addr_max", 32'(ram_address), 32'(320 * ((VV - 1) / 2) + (HV - 1) / 2));
        run_to(((VV + VF) * HT) * CD);
        chk("vsync_before_fall", 32'(vga_vsync), 32'd1);
        run_to(((VV + VF) * HT + 1) * CD);
        chk("vsync_fall", 32'(vga_vsync), 32'd0);
        run_to(((VV + VF + VS) * HT + 1) * CD);
        chk("vsync_rise", 32'(vga_vsync), 32'd1);
        run_to(CD * FRAME + 4);

        // Blanking with an all-white picture.
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 76800; i++) mem[i] = 3'b111;
        repeat (2) @(negedge clock);
        check_all();
        release_reset();
        white = 0;
        for (int i = 0; i < CD * FRAME + CD; i++) begin
            step();
            if (n >= CD && n < CD + CD * FRAME && {vga_r, vga_g, vga_b} === 12'hFFF) white++;
        end
        chk("white_clocks", 32'(white), 32'(HV * VV * CD));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
